l2_line_responder: RTL and testbench

Next-level (L2) responder for the split L1 instruction and data caches. It accepts line-fill and write-back requests on two independent request ports and arbitrates between them. Each granted request is served after a fixed latency, from a small direct-mapped line store backed by a deterministic address pattern. It also counts the traffic it serves for the statistics block.

---
 rtl/l2_line_responder.sv | 146 ++++++++++++++
 tb/tb_l2_line_responder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/l2_line_responder.sv
// L2 line responder: round-robin arbitration between the L1 I and D request
// ports, fixed-latency service from a direct-mapped line store, traffic counters.
module l2_line_responder #(
  parameter int IDX_W = 6,
  parameter int LAT   = 4
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         i_req,
  input  logic [25:0]  i_add,
  output logic         i_ack,
  output logic [511:0] i_data,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [25:0]  d_add,
  input  logic [511:0] d_wdata,
  output logic         d_ack,
  output logic [511:0] d_data,
  output logic         busy,
  output logic [31:0]  i_reads,
  output logic [31:0]  d_reads,
  output logic [31:0]  d_writes
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 26 - IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                grant, grant_d, commit;
  logic [3:0]          cnt;
  logic                sel_d, lat_we, last_d;
  logic [25:0]         lat_add;
  logic [511:0]        lat_wdata;
  logic [LINES-1:0]    valid;
  logic [511:0]        mem     [LINES];
  logic [TAG_W-1:0]    tag_mem [LINES];
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    lat_tag;
  logic                hit;
  logic [15:0][31:0]   pat;
  logic [511:0]        resp;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Ties go to the port that did not win last time; a lone requester always wins.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (i_req || d_req) begin
        grant     = 1'b1;
        grant_d   = d_req && (!i_req || !last_d);
        state_nxt = WAIT;
      end
      WAIT: if (cnt == 4'd0) begin
        commit    = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign idx     = lat_add[IDX_W-1:0];
  assign lat_tag = lat_add[25:IDX_W];
  assign hit     = valid[idx] && (tag_mem[idx] == lat_tag);

  genvar k;
  generate
    for (k = 0; k < 16; k++) begin : g_pat
      assign pat[k] = {lat_add, 4'(k), 2'b00};
    end
  endgenerate

  assign resp = lat_we ? lat_wdata : (hit ? mem[idx] : pat);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt       <= '0;
      sel_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_add   <= '0;
      lat_wdata <= '0;
      last_d    <= 1'b0;
      valid     <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_data    <= '0;
      d_data    <= '0;
      i_reads   <= '0;
      d_reads   <= '0;
      d_writes  <= '0;
    end else begin
      if (grant) begin
        sel_d     <= grant_d;
        lat_we    <= grant_d && d_we;
        lat_add   <= grant_d ? d_add : i_add;
        lat_wdata <= d_wdata;
        cnt       <= 4'(LAT - 1);
        last_d    <= grant_d;
      end
      if (state == WAIT && !commit) cnt <= cnt - 4'd1;
      if (commit) begin
        i_ack  <= !sel_d;
        d_ack  <= sel_d;
        i_data <= sel_d ? '0 : resp;
        d_data <= sel_d ? resp : '0;
        if (sel_d && lat_we) begin
          valid[idx] <= 1'b1;
          d_writes   <= sat_inc(d_writes);
        end else if (sel_d) begin
          d_reads    <= sat_inc(d_reads);
        end else begin
          i_reads    <= sat_inc(i_reads);
        end
      end
      if (state == RESP) begin
        i_ack  <= 1'b0;
        d_ack  <= 1'b0;
        i_data <= '0;
        d_data <= '0;
      end
    end
  end

  // Store arrays carry no reset; only the valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (commit && sel_d && lat_we) begin
      mem[idx]     <= lat_wdata;
      tag_mem[idx] <= lat_tag;
    end
  end

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder: pattern reads, write/read-back,
// index conflicts, tie arbitration order/spacing and reset during service.
module tb_l2_line_responder;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         clear_n;
  logic         i_req, d_req, d_we;
  logic [25:0]  i_add, d_add;
  logic [511:0] d_wdata;
  logic         i_ack, d_ack, busy;
  logic [511:0] i_data, d_data;
  logic [31:0]  i_reads, d_reads, d_writes;

  int checks = 0;
  int errors = 0;

  l2_line_responder #(.IDX_W(6), .LAT(LAT)) dut (
    .clk(clk), .clear_n(clear_n),
    .i_req(i_req), .i_add(i_add), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_add(d_add), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_data(d_data), .busy(busy),
    .i_reads(i_reads), .d_reads(d_reads), .d_writes(d_writes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [25:0] a);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = {a, 4'(k), 2'b00};
    return r;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that closes RESP.
  task automatic txn(input bit dp, input bit we, input logic [25:0] a,
                     input logic [511:0] wd, output logic [511:0] rd, output int n);
    bit seen = 0;
    if (dp) begin d_req = 1; d_we = we; d_add = a; d_wdata = wd; end
    else    begin i_req = 1; i_add = a; end
    n = 0;
    rd = '0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      seen = dp ? d_ack : i_ack;
    end
    chk("ack_timeout", seen, 1'b1);
    rd = dp ? d_data : i_data;
    chk("other_bus_zero", dp ? i_data : d_data, '0);
    i_req = 0; d_req = 0;
    @(posedge clk); #1;
    chk("ack_one_cycle", {i_ack, d_ack}, 2'b00);
  endtask

  logic [511:0] rd, wl;
  int           n;
  int           cyc, nack;
  bit           ack_port [4];
  int           ack_cyc  [4];
  bit           stray;

  initial begin
    clear_n = 0; i_req = 1; d_req = 1; d_we = 1;
    i_add = 26'($urandom); d_add = 26'($urandom); d_wdata = {16{$urandom}};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acks", {i_ack, d_ack, busy}, 3'b000);
    chk("rst_data", i_data | d_data, '0);
    chk("rst_cnts", {i_reads, d_reads, d_writes}, '0);
    i_req = 0; d_req = 0; d_we = 0;
    clear_n = 1;

    // Pattern read: 0x123 << 6 = 0x48C0
    txn(0, 0, 26'h0000123, '0, rd, n);
    chk("pat_latency", n, LAT + 1);
    chk("pat_w0", rd[31:0], 32'h0000_48C0);
    chk("pat_w15", rd[511:480], 32'h0000_48FC);
    chk("pat_line", rd, pat(26'h0000123));
    chk("i_reads1", i_reads, 32'd1);

    // Write then read back
    wl = {16{32'h0BEEFA55}};
    txn(1, 1, 26'h40, wl, rd, n);
    chk("wr_echo", rd, wl);
    chk("wr_latency", n, LAT + 1);
    txn(1, 0, 26'h40, '0, rd, n);
    chk("rd_after_wr", rd, wl);
    chk("d_writes1", d_writes, 32'd1);
    chk("d_reads1", d_reads, 32'd1);

    // Same index, different tag: miss returns pattern, original line untouched
    txn(1, 0, 26'h80, '0, rd, n);
    chk("conflict_pat", rd, pat(26'h80));
    txn(1, 0, 26'h40, '0, rd, n);
    chk("conflict_keep", rd, wl);
    txn(0, 0, 26'h40, '0, rd, n);
    chk("i_sees_write", rd, wl);
    chk("cnts_after", {i_reads, d_reads, d_writes}, {32'd2, 32'd3, 32'd1});

    // Ties from reset: D, I, D, I with LAT+2 spacing
    clear_n = 0; #1; clear_n = 1;
    i_add = 26'h11; d_add = 26'h22; d_we = 0;
    i_req = 1; d_req = 1;
    cyc = 0; nack = 0;
    while (nack < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (i_ack || d_ack) begin
        ack_port[nack] = d_ack;
        ack_cyc[nack]  = cyc;
        if (i_ack && d_ack) chk("tie_both_ack", 1'b1, 1'b0);
        chk("tie_data", d_ack ? d_data : i_data, d_ack ? pat(26'h22) : pat(26'h11));
        nack++;
      end
    end
    i_req = 0; d_req = 0;
    chk("tie_count", nack, 4);
    chk("tie_order", {ack_port[0], ack_port[1], ack_port[2], ack_port[3]}, 4'b1010);
    chk("tie_first", ack_cyc[0], LAT + 1);
    chk("tie_gap1", ack_cyc[1] - ack_cyc[0], LAT + 2);
    chk("tie_gap3", ack_cyc[3] - ack_cyc[2], LAT + 2);
    @(posedge clk); @(posedge clk); #1;

    // Reset two cycles into a write: nothing commits
    d_req = 1; d_we = 1; d_add = 26'h100; d_wdata = {16{32'hCAFE_F00D}};
    @(posedge clk); @(posedge clk); #1;
    chk("mid_busy", busy, 1'b1);
    clear_n = 0; #1;
    chk("mid_rst_out", {busy, d_ack, d_data}, '0);
    d_req = 0; d_we = 0;
    @(posedge clk); #1;
    clear_n = 1;
    stray = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (d_ack || i_ack) stray = 1;
    end
    chk("mid_no_ack", stray, 1'b0);
    txn(1, 0, 26'h100, '0, rd, n);
    chk("mid_not_written", rd, pat(26'h100));
    chk("mid_latency", n, LAT + 1);
    chk("mid_cnts", {d_writes, d_reads}, {32'd0, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
